// File: rtl/module_sevenseg_scan_if.sv
// Load port of module_sevenseg_scan: one valid/ready transfer carries every digit nibble.
// Digit k occupies data[4k+3:4k]; digit 0 is the rightmost.
interface module_sevenseg_scan_if #(
  parameter int N_DIGITS = 4
) ();
  logic [4*N_DIGITS-1:0] data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/module_sevenseg_scan.sv
// Time-multiplexed scan controller for a common-anode 7-seg display driving one shared decoder.
// Optional feature macro: LEADING_ZERO_BLANK_EN (keeps leading-zero digits dark).
module module_sevenseg_scan #(
  parameter  int N_DIGITS     = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 100,
  localparam int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  module_sevenseg_scan_if.slave        load,
  output logic [3:0]                   num_o,
  output logic [N_DIGITS-1:0]          an_o,
  output logic [IDX_W-1:0]             digit_idx_o,
  output logic                         frame_done_o
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_ON
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*N_DIGITS-1:0]   disp;
  logic [4*N_DIGITS-1:0]   shadow;
  logic                    pending;

  logic                    slot_end;
  logic                    wrap;
  logic                    accept;
  logic                    commit;
  logic                    start_digit;
  logic [4*N_DIGITS-1:0]   disp_next;
  logic [IDX_W-1:0]        idx_next;
  logic [IDX_W-1:0]        sel;
  logic [3:0]              sel_nib;
  logic [N_DIGITS-1:0]     sel_an;
  logic [N_DIGITS-1:0]     lit;

  // The shadow only reaches the display at a frame wrap or while the scan is off,
  // so a frame never mixes old and new digits.
  always_comb begin
    slot_end    = (cnt == '0);
    wrap        = (state == ST_ON) && slot_end && (idx == IDX_LAST);
    accept      = load.data_valid && !pending;
    commit      = pending && ((state == ST_OFF) || (wrap && enable_i));
    disp_next   = commit ? shadow : disp;
    idx_next    = wrap ? '0 : idx + IDX_W'(1);
    start_digit = (state == ST_OFF) || ((state == ST_ON) && slot_end);
    if (state == ST_OFF) begin
      sel = '0;
    end else if ((state == ST_ON) && slot_end) begin
      sel = idx_next;
    end else begin
      sel = idx;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit stays dark when it and every digit to its left are zero; digit 0 always lights.
  always_comb begin
    lit    = '1;
    for (int k = 1; k < N_DIGITS; k++) begin
      lit[k] = |(disp_next >> (4 * k));
    end
  end
`else
  assign lit = '1;
`endif

  always_comb begin
    sel_nib = '0;
    sel_an  = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (sel == IDX_W'(k)) begin
        sel_nib   = disp_next[4*k +: 4];
        sel_an[k] = !lit[k];
      end
    end
  end

  // Scan FSM: one down-counter times both the blank and the lit phase of every digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_OFF;
      cnt          <= '0;
      idx          <= '0;
      an_o         <= '1;
      num_o        <= '0;
      frame_done_o <= 1'b0;
      disp         <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      disp         <= disp_next;
      if (accept) begin
        shadow  <= load.data;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      if (!enable_i) begin
        state <= ST_OFF;
        cnt   <= '0;
        idx   <= '0;
        an_o  <= '1;
        num_o <= '0;
      end else if (start_digit) begin
        idx          <= sel;
        num_o        <= sel_nib;
        frame_done_o <= wrap;
        if (HAS_BLANK) begin
          state <= ST_BLANK;
          cnt   <= BLANK_LOAD;
          an_o  <= '1;
        end else begin
          state <= ST_ON;
          cnt   <= ON_LOAD;
          an_o  <= sel_an;
        end
      end else begin
        case (state)
          ST_BLANK: begin
            if (slot_end) begin
              state <= ST_ON;
              cnt   <= ON_LOAD;
              an_o  <= sel_an;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_ON: begin
            cnt <= cnt - CNT_W'(1);
          end
          default: begin
            state <= ST_OFF;
            an_o  <= '1;
          end
        endcase
      end
    end
  end

  assign load.data_ready = ~pending;
  assign digit_idx_o     = idx;

endmodule
